// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: per-stage payload
// layouts, their widths, the bubble values loaded on flush and the default
// performance counter width.
package pipe_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        MDU_DUM  = 3'd0,
        MDU_MUL  = 3'd1,
        MDU_MULH = 3'd2,
        MDU_DIV  = 3'd3,
        MDU_REM  = 3'd4
    } mdu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [4:0]  rd;
        mdu_op_e     mduOp;
        logic        regWe;
        logic        memWe;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] aluRes;
        logic [31:0] storeData;
        logic [4:0]  rd;
        logic        regWe;
        logic        memWe;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wbData;
        logic [4:0]  rd;
        logic        regWe;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    // Bubbles: no write-enables, and the MDU op parks on its dummy encoding.
    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: '0};
    localparam id_ex_t ID_EX_BUBBLE = '{pc: '0, rs1Val: '0, rs2Val: '0, rd: '0,
                                        mduOp: MDU_DUM, regWe: 1'b0, memWe: 1'b0};
    localparam ex_mem_t EX_MEM_BUBBLE = '{aluRes: '0, storeData: '0, rd: '0,
                                          regWe: 1'b0, memWe: 1'b0};
    localparam mem_wb_t MEM_WB_BUBBLE = '{wbData: '0, rd: '0, regWe: 1'b0};

endpackage

// File: rtl/pipe_stage_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
// slave is the stage itself; master is whatever drives it (neighbouring
// stages, hazard unit, testbench).
interface pipe_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             hold;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, hold, flush, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, hold, flush, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualifying cycles until the counter is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Reusable handshaked pipeline stage register with optional one-entry skid
// buffer, hold/flush control and saturating stall/bubble counters.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int unsigned      SKID   = 1,
    parameter int unsigned      CNT_W  = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             mainV;
    logic [WIDTH-1:0] mainD;
    logic             acceptIn;
    logic             releaseOut;

    assign bus.out_valid = mainV && !bus.hold;
    assign bus.out_data  = mainD;
    assign acceptIn      = bus.in_valid && bus.in_ready;
    assign releaseOut    = bus.out_valid && bus.out_ready;

    if (SKID == 1) begin : gSkid
        logic             skidV;
        logic [WIDTH-1:0] skidD;

        // Registered ready: only a full skid entry (or control) blocks upstream.
        assign bus.in_ready = !skidV && !bus.hold && !bus.flush && !reset;

        // Main/skid register pair; skid drains into main before new input.
        always_ff @(posedge clk) begin
            if (reset || bus.flush) begin
                mainV <= 1'b0;
                mainD <= BUBBLE;
                skidV <= 1'b0;
                skidD <= BUBBLE;
            end else if (!bus.hold) begin
                if (releaseOut) begin
                    if (skidV) begin
                        mainD <= skidD;
                        skidV <= 1'b0;
                    end else if (acceptIn) begin
                        mainD <= bus.in_data;
                    end else begin
                        mainV <= 1'b0;
                    end
                end else if (acceptIn) begin
                    if (!mainV) begin
                        mainV <= 1'b1;
                        mainD <= bus.in_data;
                    end else begin
                        skidV <= 1'b1;
                        skidD <= bus.in_data;
                    end
                end
            end
        end
    end else begin : gNoSkid
        // Ready passes straight through from downstream when main is occupied.
        assign bus.in_ready = !bus.hold && !bus.flush && !reset &&
                              (!mainV || bus.out_ready);

        // Single register: load on accept, empty on release without refill.
        always_ff @(posedge clk) begin
            if (reset || bus.flush) begin
                mainV <= 1'b0;
                mainD <= BUBBLE;
            end else if (!bus.hold) begin
                if (acceptIn) begin
                    mainV <= 1'b1;
                    mainD <= bus.in_data;
                end else if (releaseOut) begin
                    mainV <= 1'b0;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.in_valid && !bus.in_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uBubbleCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.out_ready && !bus.out_valid),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Testbench for pipe_stage: three instances driven in lockstep from shared
// stimulus (SKID=1 with a non-zero bubble, SKID=0, SKID=1 with 4-bit
// counters), each compared every cycle against a capacity-bounded FIFO model.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        reset, inValid, hold, flush, outReady;
    logic [31:0] inData;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_if #(.WIDTH(32)) ifA ();
    pipe_stage_if #(.WIDTH(32)) ifB ();
    pipe_stage_if #(.WIDTH(32)) ifC ();

    assign ifA.in_valid = inValid;  assign ifB.in_valid = inValid;  assign ifC.in_valid = inValid;
    assign ifA.in_data  = inData;   assign ifB.in_data  = inData;   assign ifC.in_data  = inData;
    assign ifA.hold     = hold;     assign ifB.hold     = hold;     assign ifC.hold     = hold;
    assign ifA.flush    = flush;    assign ifB.flush    = flush;    assign ifC.flush    = flush;
    assign ifA.out_ready = outReady; assign ifB.out_ready = outReady; assign ifC.out_ready = outReady;

    logic [15:0] stallA, bubA, stallB, bubB;
    logic [3:0]  stallC, bubC;

    pipe_stage #(.WIDTH(32), .BUBBLE(32'hDEAD0000), .SKID(1), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .bus(ifA.slave), .stall_cnt(stallA), .bubble_cnt(bubA));
    pipe_stage #(.WIDTH(32), .BUBBLE(32'h000000A5), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .bus(ifB.slave), .stall_cnt(stallB), .bubble_cnt(bubB));
    pipe_stage #(.WIDTH(32), .BUBBLE(32'h00000000), .SKID(1), .CNT_W(4)) dutC (
        .clk(clk), .reset(reset), .bus(ifC.slave), .stall_cnt(stallC), .bubble_cnt(bubC));

    logic        obsRdy[3], obsVal[3];
    logic [31:0] obsData[3], obsStall[3], obsBub[3];

    assign obsRdy[0] = ifA.in_ready;  assign obsVal[0] = ifA.out_valid;  assign obsData[0] = ifA.out_data;
    assign obsRdy[1] = ifB.in_ready;  assign obsVal[1] = ifB.out_valid;  assign obsData[1] = ifB.out_data;
    assign obsRdy[2] = ifC.in_ready;  assign obsVal[2] = ifC.out_valid;  assign obsData[2] = ifC.out_data;
    assign obsStall[0] = {16'b0, stallA};  assign obsBub[0] = {16'b0, bubA};
    assign obsStall[1] = {16'b0, stallB};  assign obsBub[1] = {16'b0, bubB};
    assign obsStall[2] = {28'b0, stallC};  assign obsBub[2] = {28'b0, bubC};

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid)
    // whose visible data is the head, or the last shown value when empty.
    logic [31:0] mDat[3][2];
    int unsigned mCnt[3];
    logic [31:0] mShown[3];
    int unsigned mStall[3], mBub[3];

    function automatic logic [31:0] bubbleOf(input int unsigned i);
        case (i)
            0:       return 32'hDEAD0000;
            1:       return 32'h000000A5;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic int unsigned satMax(input int unsigned i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic logic modelReady(input int unsigned i);
        if (hold || flush || reset) return 1'b0;
        if (i == 1) return (mCnt[i] == 0) || outReady;
        return mCnt[i] < 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: compare all outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        logic rdy, ov, acc, rel;
        @(negedge clk);
        for (int unsigned i = 0; i < 3; i++) begin
            rdy = modelReady(i);
            ov  = (mCnt[i] != 0) && !hold;
            check($sformatf("d%0d in_ready", i),   {31'b0, obsRdy[i]}, {31'b0, rdy});
            check($sformatf("d%0d out_valid", i),  {31'b0, obsVal[i]}, {31'b0, ov});
            check($sformatf("d%0d out_data", i),   obsData[i], mShown[i]);
            check($sformatf("d%0d stall_cnt", i),  obsStall[i], mStall[i]);
            check($sformatf("d%0d bubble_cnt", i), obsBub[i], mBub[i]);
            acc = inValid && rdy;
            rel = ov && outReady;
            if (reset) begin
                mStall[i] = 0;
                mBub[i]   = 0;
            end else begin
                if (inValid && !rdy && mStall[i] < satMax(i)) mStall[i]++;
                if (outReady && !ov && mBub[i] < satMax(i))   mBub[i]++;
            end
            if (reset || flush) begin
                mCnt[i]   = 0;
                mShown[i] = bubbleOf(i);
            end else if (!hold) begin
                if (rel) begin
                    mDat[i][0] = mDat[i][1];
                    mCnt[i]--;
                end
                if (acc) begin
                    mDat[i][mCnt[i]] = inData;
                    mCnt[i]++;
                end
                if (mCnt[i] != 0) mShown[i] = mDat[i][0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int unsigned i = 0; i < 3; i++) begin
            mCnt[i] = 0; mShown[i] = bubbleOf(i); mStall[i] = 0; mBub[i] = 0;
        end
        reset = 1'b1; inValid = 1'b0; hold = 1'b0; flush = 1'b0; outReady = 1'b0; inData = '0;

        // Reset for two cycles; the first edge establishes known state.
        @(posedge clk); #1;
        step();
        reset = 1'b0;
        #1;
        check("ready after reset", {31'b0, ifA.in_ready}, 32'd1);

        // Stream 1,2,3 with downstream always ready.
        outReady = 1'b1;
        inValid = 1'b1; inData = 32'h1; step();
        check("stream first data", ifA.out_data, 32'h1);
        check("stream first valid", {31'b0, ifA.out_valid}, 32'd1);
        inData = 32'h2; step();
        inData = 32'h3; step();
        inValid = 1'b0; step(); step();
        check("stream stall_cnt", {16'b0, stallA}, 32'd0);

        // Backpressure: two beats land in main and skid, then upstream stalls.
        outReady = 1'b0;
        inValid = 1'b1; inData = 32'hA; step();
        inData = 32'hB; step();
        check("bp main", ifA.out_data, 32'hA);
        check("bp ready", {31'b0, ifA.in_ready}, 32'd0);
        inData = 32'hC; step(); step();
        inValid = 1'b0; outReady = 1'b1;
        repeat (4) step();

        // Hold with 0x55 resident, then release.
        outReady = 1'b0;
        inValid = 1'b1; inData = 32'h55; step();
        hold = 1'b1; outReady = 1'b1; inData = 32'h66;
        repeat (3) step();
        hold = 1'b0; inValid = 1'b0;
        #1;
        check("hold release data", ifA.out_data, 32'h55);
        repeat (3) step();

        // Flush with a full skid and a beat on the input.
        outReady = 1'b0;
        inValid = 1'b1; inData = 32'h71; step();
        inData = 32'h72; step();
        flush = 1'b1; inData = 32'h73; step();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        #1;
        check("flush data", ifA.out_data, 32'hDEAD0000);
        check("flush valid", {31'b0, ifA.out_valid}, 32'd0);
        check("flush skid empty", {31'b0, ifA.in_ready}, 32'd1);
        repeat (3) step();

        // Idle with downstream ready: 4-bit bubble counter saturates.
        repeat (20) step();
        check("bubble saturation", {28'b0, bubC}, 32'd15);

        // Randomised traffic with occasional hold, flush and reset.
        for (int n = 0; n < 10000; n++) begin
            inValid  = $urandom_range(0, 1) == 1;
            outReady = $urandom_range(0, 3) != 0;
            inData   = $urandom;
            hold     = $urandom_range(0, 15) == 0;
            flush    = $urandom_range(0, 31) == 0;
            reset    = $urandom_range(0, 511) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised, handshaked pipeline stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries an opaque WIDTH-bit payload from an upstream stage to a downstream stage. Transfers use valid/ready handshakes with an optional one-entry skid buffer. The stage supports hold (freeze) and flush (bubble insertion) and has saturating stall/bubble performance counters. Flush loads a per-instance bubble value, so control fields such as the MDU op can reset to their "dummy" encoding rather than zero.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1).
- BUBBLE, '0, payload value loaded on reset and flush.
- SKID, 1, 1 = one-entry skid buffer (registered in_ready path); 0 = no skid (in_ready combinational from out_ready).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- hold  in  1  freeze: no accept, no release.
- flush  in  1  discard all held and incoming payloads.
- out_valid  out  1  payload valid to downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream.
- stall_cnt  out  CNT_W  cycles with in_valid && !in_ready.
- bubble_cnt  out  CNT_W  cycles with out_ready && !out_valid.

## Operation
- State:
  - main register: main_v, main_d.
  - skid register (SKID=1 only): skid_v, skid_d.
- Output and handshake signals:
  - out_valid = main_v && !hold.
  - out_data = main_d.
  - Accept = in_valid && in_ready.
  - Release = out_valid && out_ready.
- in_ready:
  - SKID=1: !skid_v && !hold && !flush && !reset.
  - SKID=0: !hold && !flush && !reset && (!main_v || out_ready).
- Update priority: reset > flush > hold > normal.
- Flush:
  - main_v and skid_v cleared.
  - main_d and skid_d loaded with BUBBLE.
  - Same-cycle in_data is dropped.
  - Flush wins over hold.
- Hold: all payload registers keep their values.
- Normal operation (SKID=1):
  - Release with skid_v set: main ← skid, skid_v ← 0.
  - Release, no skid, Accept: main ← in.
  - Release, no skid, no Accept: main_v ← 0.
  - No Release, main empty, Accept: main ← in.
  - No Release, main full, Accept: skid ← in.
- Normal operation (SKID=0): main ← in on Accept; main_v ← 0 on Release without Accept.
- Ordering: no payload is lost, duplicated or reordered outside flush.
- Counters:
  - Saturate at 2^CNT_W−1 (no wrap).
  - Cleared only by reset; flush does not clear them.
  - Counting continues during hold.

## Timing
- Reset values: out_valid 0, out_data BUBBLE, in_ready 0 while reset is asserted (1 on the first cycle after), skid empty, stall_cnt 0, bubble_cnt 0.
- Latency: in_data accepted at edge N appears on out_data after edge N (one cycle).
- Throughput: one transfer per cycle sustained when out_ready is held high.
- SKID=1: in_ready depends only on registered state plus hold/flush/reset, with no out_ready→in_ready combinational path. At most one extra beat is absorbed after out_ready falls.
- Flush asserted in the same cycle as Accept or Release: neither transfer is counted as completed upstream state. The downstream sample of out_data in that cycle is still valid if out_valid was high, because the flush takes effect at the edge.
- Reset asserted mid-transfer: all payload is discarded, identical to flush, and counters are cleared.

## Structure
- Shared package pipe_pkg holds:
  - per-stage payload struct widths;
  - bubble constants (e.g. ID/EX bubble with MDU op = MDU_DUM, all write-enables 0);
  - the default counter width.
- Sub-module sat_counter (CNT_W, inc, reset) is instantiated twice for stall_cnt and bubble_cnt.

## Test plan
- Reset then stream: hold reset 2 cycles, then drive 0x1,0x2,0x3 on consecutive cycles with out_ready=1. Required: out_data 0x1,0x2,0x3 one cycle later, out_valid high 3 cycles, stall_cnt 0.
- Backpressure (SKID=1): out_ready=0 while sending 0xA,0xB. Required:
  - main holds 0xA, skid holds 0xB, in_ready 0, stall_cnt increments while in_valid is held.
  - On raising out_ready: 0xA then 0xB, no loss.
- Hold: set hold=1 with main holding 0x55. Required: out_valid 0 and in_ready 0 for the hold duration; 0x55 is released after hold drops.
- Flush with full skid and in_valid high. Required: next cycle out_valid 0, out_data = BUBBLE (e.g. 0xDEAD0000), skid empty, dropped input never appears.
- Counter saturation (CNT_W=4): out_ready=1, no input, 20 cycles. Required: bubble_cnt stops at 15.
- SKID=0 variant: random valid/ready for 10k cycles against a scoreboard. Required: in-order, lossless delivery, and in_ready == !main_v || out_ready whenever not held or flushed.
